crc_calc: RTL

//  Bit-serial CRC datapath directly downstream of crc_fsm. It consumes one memory

---
 rtl/crc_calc.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/crc_calc.sv
// Bit-serial CRC datapath: accepts one memory word per crc_en strobe and folds it
// into the running CRC MSB first, one bit per clock. crc_rdy finalizes the result.
module crc_calc #(
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          CRC_WIDTH  = 16,
  parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [CRC_WIDTH-1:0] INIT       = 16'hFFFF,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT    = 16'h0000
) (
  input  logic                  clk50m,
  input  logic                  rst_n,
  input  logic                  crc_start,
  input  logic                  crc_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  crc_rdy,
  output logic                  crc_busy,
  output logic [CRC_WIDTH-1:0]  crc_out,
  output logic                  crc_valid,
  output logic                  crc_err
);

  localparam int unsigned   CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic [CRC_WIDTH-1:0]  out_q, out_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  pend_q, pend_d;

  logic                  fb;
  logic [CRC_WIDTH-1:0]  crc_step;

  // One LFSR step using the current MSB of the latched word.
  always_comb begin
    fb       = crc_q[CRC_WIDTH-1] ^ sh_q[DATA_WIDTH-1];
    crc_step = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  // Next-state logic: crc_start overrides everything else in the cycle.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    out_d   = out_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    pend_d  = pend_q;

    if (crc_start) begin
      state_d = StIdle;
      crc_d   = INIT;
      out_d   = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (crc_en) begin
            sh_d    = mem_data;
            cnt_d   = CntLast;
            state_d = StShift;
            // rdy with en: byte goes first, finalize afterwards
            pend_d  = crc_rdy;
          end else if (crc_rdy) begin
            state_d = StDone;
            out_d   = crc_q ^ XOR_OUT;
            valid_d = 1'b1;
          end
        end
        StShift: begin
          crc_d = crc_step;
          sh_d  = sh_q << 1;
          if (crc_en) begin
            err_d = 1'b1;
          end
          if (crc_rdy) begin
            pend_d = 1'b1;
          end
          if (cnt_q == '0) begin
            if (pend_q || crc_rdy) begin
              state_d = StDone;
              out_d   = crc_step ^ XOR_OUT;
              valid_d = 1'b1;
              pend_d  = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (crc_en) begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers, asynchronous reset only.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      crc_q   <= INIT;
      out_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      out_q   <= out_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    crc_busy  = (state_q == StShift);
    crc_out   = out_q;
    crc_valid = valid_q;
    crc_err   = err_q;
  end

endmodule
